// File: rtl/sim_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
// The message strings are only printed when SIM_SEQ_AUTO_FINISH_EN is defined.
package sim_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    TIMEOUT = 2'd3
  } seq_state_t;

  localparam int unsigned SIM_SEQ_CNT_W = 32;

  localparam string MSG_WDOG_TIMEOUT = "warn: watchdog timeout";
  localparam string MSG_MAX_CYCLES   = "warn: Max simulation cycles reached";

endpackage

// File: rtl/sim_sat_counter.sv
// Up-counter that holds at all-ones; synchronous clear has priority over increment.
module sim_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sim_reset_sequencer.sv
// Staged multi-channel reset release with idle watchdog and cycle limit (sticky flags).
// Define SIM_SEQ_AUTO_FINISH_EN to print a warning and call $finish when either flag first rises.
module sim_reset_sequencer #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned RESET_DELAY = 4,
  parameter int unsigned STAGE_GAP   = 2,
  parameter int unsigned WDOG_CYCLES = 16,
  parameter int unsigned MAX_CYCLES  = 1000,
  parameter int unsigned CNT_W       = sim_seq_pkg::SIM_SEQ_CNT_W
) (
  input  logic              USER_CLK,
  input  logic              USER_RSTN,
  input  logic              SOFT_RST_REQ,
  input  logic              ACTIVITY,
  output logic [NUM_CH-1:0] CH_RSTN,
  output logic [NUM_CH-1:0] CH_RST,
  output logic              ALL_RELEASED,
  output logic              TIMEOUT,
  output logic              MAX_REACHED,
  output logic [CNT_W-1:0]  CYCLE_COUNT,
  output logic [1:0]        STATE
);

  import sim_seq_pkg::*;

  localparam int unsigned DLY_MAX = RESET_DELAY + (NUM_CH - 1) * STAGE_GAP;
  localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);
  localparam int unsigned IDLE_W  = (WDOG_CYCLES == 0) ? 1 : $clog2(WDOG_CYCLES + 1);
  localparam logic [IDLE_W-1:0] WDOG_LAST = IDLE_W'((WDOG_CYCLES == 0) ? 0 : WDOG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  MAX_LAST  = CNT_W'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);

  seq_state_t        state_q, state_n;
  logic [NUM_CH-1:0] ch_rstn_q, ch_rstn_n;
  logic              all_q, all_n;
  logic              timeout_q, timeout_n;
  logic              max_q, max_n;
  logic [DLY_W-1:0]  dly_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [NUM_CH-1:0] stage_hit;
  logic              dly_clr, idle_clr, wdog_hit;

  // The delay counter keeps running through RELEASE, so channel k's release edge is a fixed count.
  assign dly_clr  = SOFT_RST_REQ || !(state_q inside {ASSERT, RELEASE});
  assign idle_clr = SOFT_RST_REQ || ACTIVITY || (state_q != RUN);
  assign wdog_hit = (WDOG_CYCLES != 0) && !ACTIVITY && (idle_cnt == WDOG_LAST);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_stage
    assign stage_hit[k] = (dly_cnt == DLY_W'(RESET_DELAY - 1 + k * STAGE_GAP));
  end

  sim_sat_counter #(.WIDTH(DLY_W)) u_dly_cnt (
    .clk   (USER_CLK),
    .rstn  (USER_RSTN),
    .clr   (dly_clr),
    .inc   (1'b1),
    .count (dly_cnt)
  );

  sim_sat_counter #(.WIDTH(IDLE_W)) u_idle_cnt (
    .clk   (USER_CLK),
    .rstn  (USER_RSTN),
    .clr   (idle_clr),
    .inc   (1'b1),
    .count (idle_cnt)
  );

  sim_sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk   (USER_CLK),
    .rstn  (USER_RSTN),
    .clr   (1'b0),
    .inc   (1'b1),
    .count (cycle_cnt)
  );

  always_comb begin
    state_n   = state_q;
    ch_rstn_n = ch_rstn_q;
    all_n     = all_q;
    timeout_n = timeout_q;
    max_n     = max_q | ((MAX_CYCLES != 0) && (cycle_cnt == MAX_LAST));
    unique case (state_q)
      ASSERT: begin
        if (!SOFT_RST_REQ && stage_hit[0]) begin
          ch_rstn_n[0] = 1'b1;
          if (NUM_CH == 1) begin
            state_n = RUN;
            all_n   = 1'b1;
          end else begin
            state_n = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (SOFT_RST_REQ) begin
          state_n   = ASSERT;
          ch_rstn_n = '0;
          all_n     = 1'b0;
        end else begin
          ch_rstn_n = ch_rstn_q | stage_hit;
          if (stage_hit[NUM_CH-1]) begin
            state_n = RUN;
            all_n   = 1'b1;
          end
        end
      end
      RUN: begin
        if (SOFT_RST_REQ) begin
          state_n   = ASSERT;
          ch_rstn_n = '0;
          all_n     = 1'b0;
        end else if (wdog_hit) begin
          state_n   = sim_seq_pkg::TIMEOUT;
          timeout_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge USER_CLK or negedge USER_RSTN) begin
    if (!USER_RSTN) begin
      state_q   <= ASSERT;
      ch_rstn_q <= '0;
      all_q     <= 1'b0;
      timeout_q <= 1'b0;
      max_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      ch_rstn_q <= ch_rstn_n;
      all_q     <= all_n;
      timeout_q <= timeout_n;
      max_q     <= max_n;
    end
  end

  assign CH_RSTN      = ch_rstn_q;
  assign CH_RST       = ~ch_rstn_q;
  assign ALL_RELEASED = all_q;
  assign TIMEOUT      = timeout_q;
  assign MAX_REACHED  = max_q;
  assign CYCLE_COUNT  = cycle_cnt;
  assign STATE        = state_q;

`ifdef SIM_SEQ_AUTO_FINISH_EN
  logic [CNT_W-1:0] cycle_nxt;
  assign cycle_nxt = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + 1'b1;

  // Reports the count as it will read after this edge, matching the flag that rises here.
  always @(posedge USER_CLK) begin
    if (USER_RSTN) begin
      if (timeout_n && !timeout_q) $display("%s (cycle %0d)", MSG_WDOG_TIMEOUT, cycle_nxt);
      if (max_n && !max_q) $display("%s (cycle %0d)", MSG_MAX_CYCLES, cycle_nxt);
      if ((timeout_n && !timeout_q) || (max_n && !max_q)) $finish;
    end
  end
`endif

endmodule

// File: tb/tb_sim_reset_sequencer.sv
// Directed self-checking bench for sim_reset_sequencer (3 channels, delay 4, gap 2, watchdog 16, limit 50).
module tb_sim_reset_sequencer;

  logic        user_clk = 1'b0;
  logic        user_rstn;
  logic        soft_rst_req;
  logic        activity;
  logic [2:0]  ch_rstn;
  logic [2:0]  ch_rst;
  logic        all_released;
  logic        timeout;
  logic        max_reached;
  logic [31:0] cycle_count;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  always #5 user_clk = ~user_clk;

  sim_reset_sequencer #(
    .NUM_CH      (3),
    .RESET_DELAY (4),
    .STAGE_GAP   (2),
    .WDOG_CYCLES (16),
    .MAX_CYCLES  (50),
    .CNT_W       (32)
  ) dut (
    .USER_CLK     (user_clk),
    .USER_RSTN    (user_rstn),
    .SOFT_RST_REQ (soft_rst_req),
    .ACTIVITY     (activity),
    .CH_RSTN      (ch_rstn),
    .CH_RST       (ch_rst),
    .ALL_RELEASED (all_released),
    .TIMEOUT      (timeout),
    .MAX_REACHED  (max_reached),
    .CYCLE_COUNT  (cycle_count),
    .STATE        (state)
  );

  // Advance to 1 ns after edge e; inputs set afterwards are sampled at edge e+1.
  task automatic go_to(input int e);
    while (edge_n < e) begin
      @(posedge user_clk);
      edge_n++;
      #1;
    end
  endtask

  task automatic apply_reset;
    user_rstn    = 1'b0;
    soft_rst_req = 1'b0;
    activity     = 1'b0;
    repeat (2) @(negedge user_clk);
    user_rstn = 1'b1;
    edge_n    = 0;
  endtask

  task automatic test_reset;
    user_rstn    = 1'b0;
    soft_rst_req = 1'b0;
    activity     = 1'b0;
    #1;
    checks++; if (ch_rstn !== 3'b000) begin errors++; $display("FAIL reset_ch_rstn got %b expected 000", ch_rstn); end
    checks++; if (ch_rst !== 3'b111) begin errors++; $display("FAIL reset_ch_rst got %b expected 111", ch_rst); end
    checks++; if ({all_released, timeout, max_reached} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b expected 000", {all_released, timeout, max_reached}); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycle got %0d expected 0", cycle_count); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", state); end
  endtask

  task automatic test_release;
    logic [2:0] exp_ch;
    logic [1:0] exp_st;
    apply_reset;
    for (int e = 1; e <= 10; e++) begin
      activity = (e % 4 == 0);
      go_to(e);
      exp_ch = (e >= 8) ? 3'b111 : (e >= 6) ? 3'b011 : (e >= 4) ? 3'b001 : 3'b000;
      exp_st = (e >= 8) ? 2'd2 : (e >= 4) ? 2'd1 : 2'd0;
      checks++; if (ch_rstn !== exp_ch) begin errors++; $display("FAIL release_ch_rstn edge %0d got %b expected %b", e, ch_rstn, exp_ch); end
      checks++; if (ch_rst !== ~exp_ch) begin errors++; $display("FAIL release_ch_rst edge %0d got %b expected %b", e, ch_rst, ~exp_ch); end
      checks++; if (state !== exp_st) begin errors++; $display("FAIL release_state edge %0d got %0d expected %0d", e, state, exp_st); end
      checks++; if (all_released !== (e >= 8)) begin errors++; $display("FAIL release_all edge %0d got %b expected %b", e, all_released, (e >= 8)); end
      checks++; if (cycle_count !== 32'(e)) begin errors++; $display("FAIL release_cycle edge %0d got %0d expected %0d", e, cycle_count, e); end
    end
    activity = 1'b0;
  endtask

  task automatic test_watchdog;
    apply_reset;
    go_to(23);
    checks++; if ({timeout, state} !== {1'b0, 2'd2}) begin errors++; $display("FAIL wdog_pre got to=%b st=%0d expected to=0 st=2", timeout, state); end
    go_to(24);
    checks++; if ({timeout, state} !== {1'b1, 2'd3}) begin errors++; $display("FAIL wdog_trip got to=%b st=%0d expected to=1 st=3", timeout, state); end
    checks++; if (ch_rstn !== 3'b111) begin errors++; $display("FAIL wdog_ch_rstn got %b expected 111", ch_rstn); end
    go_to(29);
    soft_rst_req = 1'b1;
    go_to(30);
    soft_rst_req = 1'b0;
    go_to(31);
    checks++; if ({timeout, state, ch_rstn, all_released} !== {1'b1, 2'd3, 3'b111, 1'b1}) begin
      errors++; $display("FAIL wdog_soft_ignored got to=%b st=%0d ch=%b all=%b expected to=1 st=3 ch=111 all=1", timeout, state, ch_rstn, all_released);
    end
  endtask

  task automatic test_activity_pulse;
    apply_reset;
    go_to(22);
    activity = 1'b1;
    go_to(23);
    activity = 1'b0;
    go_to(24);
    checks++; if ({timeout, state} !== {1'b0, 2'd2}) begin errors++; $display("FAIL pulse_no_trip24 got to=%b st=%0d expected to=0 st=2", timeout, state); end
    go_to(38);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL pulse_no_trip38 got %b expected 0", timeout); end
    go_to(39);
    checks++; if ({timeout, state} !== {1'b1, 2'd3}) begin errors++; $display("FAIL pulse_trip39 got to=%b st=%0d expected to=1 st=3", timeout, state); end
  endtask

  task automatic test_expiry_priority;
    apply_reset;
    go_to(23);
    activity = 1'b1;
    go_to(24);
    activity = 1'b0;
    checks++; if ({timeout, state} !== {1'b0, 2'd2}) begin errors++; $display("FAIL act_beats_expiry got to=%b st=%0d expected to=0 st=2", timeout, state); end
    apply_reset;
    go_to(23);
    soft_rst_req = 1'b1;
    go_to(24);
    soft_rst_req = 1'b0;
    checks++; if ({timeout, state, ch_rstn} !== {1'b0, 2'd0, 3'b000}) begin errors++; $display("FAIL soft_beats_expiry got to=%b st=%0d ch=%b expected to=0 st=0 ch=000", timeout, state, ch_rstn); end
  endtask

  task automatic test_soft_reset;
    logic [2:0] exp_ch;
    apply_reset;
    go_to(11);
    soft_rst_req = 1'b1;
    go_to(12);
    soft_rst_req = 1'b0;
    checks++; if ({ch_rstn, all_released, state} !== {3'b000, 1'b0, 2'd0}) begin errors++; $display("FAIL soft_restart got ch=%b all=%b st=%0d expected ch=000 all=0 st=0", ch_rstn, all_released, state); end
    checks++; if (cycle_count !== 32'd12) begin errors++; $display("FAIL soft_cycle_kept got %0d expected 12", cycle_count); end
    for (int e = 13; e <= 20; e++) begin
      go_to(e);
      exp_ch = (e >= 20) ? 3'b111 : (e >= 18) ? 3'b011 : (e >= 16) ? 3'b001 : 3'b000;
      checks++; if (ch_rstn !== exp_ch) begin errors++; $display("FAIL soft_rerelease edge %0d got %b expected %b", e, ch_rstn, exp_ch); end
    end
    checks++; if ({all_released, state} !== {1'b1, 2'd2}) begin errors++; $display("FAIL soft_run got all=%b st=%0d expected all=1 st=2", all_released, state); end
    checks++; if (cycle_count !== 32'd20) begin errors++; $display("FAIL soft_cycle20 got %0d expected 20", cycle_count); end
  endtask

  task automatic test_soft_in_assert;
    apply_reset;
    go_to(2);
    soft_rst_req = 1'b1;
    go_to(3);
    soft_rst_req = 1'b0;
    go_to(6);
    checks++; if ({ch_rstn, state} !== {3'b000, 2'd0}) begin errors++; $display("FAIL assert_restart6 got ch=%b st=%0d expected ch=000 st=0", ch_rstn, state); end
    go_to(7);
    checks++; if ({ch_rstn, state} !== {3'b001, 2'd1}) begin errors++; $display("FAIL assert_restart7 got ch=%b st=%0d expected ch=001 st=1", ch_rstn, state); end
  endtask

  task automatic test_async_reset;
    apply_reset;
    go_to(5);
    @(negedge user_clk);
    user_rstn = 1'b0;
    #1;
    checks++; if ({ch_rstn, ch_rst, state} !== {3'b000, 3'b111, 2'd0}) begin errors++; $display("FAIL async_outputs got ch=%b rst=%b st=%0d expected ch=000 rst=111 st=0", ch_rstn, ch_rst, state); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL async_cycle got %0d expected 0", cycle_count); end
    @(negedge user_clk);
    user_rstn = 1'b1;
    edge_n    = 0;
    go_to(3);
    checks++; if ({ch_rstn, cycle_count} !== {3'b000, 32'd3}) begin errors++; $display("FAIL async_restart3 got ch=%b cyc=%0d expected ch=000 cyc=3", ch_rstn, cycle_count); end
    go_to(4);
    checks++; if ({ch_rstn, state} !== {3'b001, 2'd1}) begin errors++; $display("FAIL async_restart4 got ch=%b st=%0d expected ch=001 st=1", ch_rstn, state); end
  endtask

  task automatic test_max_cycles;
    apply_reset;
    activity = 1'b1;
    go_to(49);
    checks++; if ({max_reached, cycle_count} !== {1'b0, 32'd49}) begin errors++; $display("FAIL max_pre got max=%b cyc=%0d expected max=0 cyc=49", max_reached, cycle_count); end
    go_to(50);
    checks++; if ({max_reached, cycle_count} !== {1'b1, 32'd50}) begin errors++; $display("FAIL max_hit got max=%b cyc=%0d expected max=1 cyc=50", max_reached, cycle_count); end
    go_to(53);
    checks++; if ({max_reached, timeout, state} !== {1'b1, 1'b0, 2'd2}) begin errors++; $display("FAIL max_sticky got max=%b to=%b st=%0d expected max=1 to=0 st=2", max_reached, timeout, state); end
    activity = 1'b0;
  endtask

  initial begin
    test_reset;
    test_release;
    test_watchdog;
    test_activity_pulse;
    test_expiry_priority;
    test_soft_reset;
    test_soft_in_assert;
    test_async_reset;
    test_max_cycles;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sim_reset_sequencer.md
Name: sim_reset_sequencer

Overview:
Parametrised successor to the team's single-reset simulation utility; lives in ver/sv/utils and is driven by the bench clock and reset.
- Releases NUM_CH reset domains in a staged order.
- Supports a bench-requested soft re-sequence.
- Adds an activity watchdog and a max-cycle limit, both reported as sticky flags.
- Intended to sit between the clock/reset source and multi-domain DUTs.

Parameters:
- NUM_CH, 3: number of reset channels (≥1).
- RESET_DELAY, 4: cycles all channels are held in reset (≥1).
- STAGE_GAP, 2: cycles between consecutive channel releases (≥1).
- WDOG_CYCLES, 16: consecutive idle cycles that trip the watchdog; 0 disables it.
- MAX_CYCLES, 1000: cycle limit (≤2^CNT_W-1).
- CNT_W, 32: cycle-counter width.

Ports:
- USER_CLK  in  1  bench clock.
- USER_RSTN  in  1  asynchronous, active-low reset.
- SOFT_RST_REQ  in  1  single-cycle request to re-run the reset sequence.
- ACTIVITY  in  1  heartbeat from the bench/DUT; clears the watchdog.
- CH_RSTN  out  NUM_CH  per-channel active-low resets.
- CH_RST  out  NUM_CH  bitwise inverse of CH_RSTN.
- ALL_RELEASED  out  1  all channels out of reset.
- TIMEOUT  out  1  watchdog tripped (sticky).
- MAX_REACHED  out  1  cycle limit hit (sticky).
- CYCLE_COUNT  out  CNT_W  cycles since USER_RSTN release, saturating.
- STATE  out  2  encoded FSM state.

Behaviour:
- Reset (USER_RSTN=0), applied asynchronously:
  - CH_RSTN=0, CH_RST=all ones.
  - ALL_RELEASED=0, TIMEOUT=0, MAX_REACHED=0, CYCLE_COUNT=0.
  - STATE=ASSERT (0).
  - All internal counters cleared.
- Edge numbering: edge 1 is the first USER_CLK rising edge with USER_RSTN=1. All outputs are registered.
- FSM states: ASSERT(0), RELEASE(1), RUN(2), TIMEOUT(3).
- ASSERT:
  - Delay counter increments every edge.
  - At edge RESET_DELAY, CH_RSTN[0] is set to 1.
  - Then go to RELEASE; if NUM_CH=1, go straight to RUN instead.
- RELEASE:
  - CH_RSTN[k] is set to 1 at edge RESET_DELAY + k*STAGE_GAP.
  - Released channels stay released.
  - ALL_RELEASED rises and the FSM enters RUN on the edge that releases channel NUM_CH-1.
- RUN:
  - Idle counter increments on each edge with ACTIVITY=0 and clears to 0 on an edge with ACTIVITY=1.
  - When the idle counter reaches WDOG_CYCLES (nonzero), go to TIMEOUT and set TIMEOUT=1 on that edge.
- TIMEOUT:
  - Terminal until USER_RSTN.
  - Channels stay released; SOFT_RST_REQ is ignored.
- SOFT_RST_REQ:
  - In RELEASE or RUN: on the next edge CH_RSTN=0, ALL_RELEASED=0, STATE=ASSERT, delay and idle counters cleared; the sequence then restarts.
  - In ASSERT: restarts the delay count.
- CYCLE_COUNT:
  - Increments every edge in all states and saturates at 2^CNT_W-1.
  - Not cleared by SOFT_RST_REQ.
- MAX_REACHED: set on the edge CYCLE_COUNT becomes MAX_CYCLES; sticky; no other effect.
- Priorities:
  - USER_RSTN overrides everything.
  - SOFT_RST_REQ beats watchdog expiry on the same edge.
  - ACTIVITY beats expiry on the same edge (counter clears, no timeout).
- Idle counter width is clog2(WDOG_CYCLES+1) and saturates.

Optional Feature:
- Macro SIM_SEQ_AUTO_FINISH_EN.
- Defined: on the edge TIMEOUT or MAX_REACHED first rises, print "warn: watchdog timeout" or "warn: Max simulation cycles reached" with the CYCLE_COUNT value, then call $finish. If both rise on the same edge, print both messages.
- Undefined: flags only; the bench decides when to end.

Decomposition:
- Package sim_seq_pkg:
  - seq_state_t enum {ASSERT, RELEASE, RUN, TIMEOUT} with 2-bit encoding.
  - Default CNT_W constant.
  - Message strings.
- Sub-module sim_sat_counter (parameter WIDTH; inputs clk, rstn, clr, inc; output saturating count), instanced for the delay, idle and cycle counters.

Test Plan:
- Defaults, ACTIVITY every 4 cycles -> CH_RSTN=001 at edge 4, 011 at edge 6, 111 at edge 8; ALL_RELEASED=1 and STATE=2 at edge 8.
- Defaults, no ACTIVITY -> TIMEOUT=1 and STATE=3 at edge 24; CH_RSTN stays 111; SOFT_RST_REQ at edge 30 has no effect.
- Single ACTIVITY pulse sampled at edge 23, none afterwards -> no trip at edge 24; TIMEOUT=1 at edge 39.
- SOFT_RST_REQ sampled at edge 12 -> CH_RSTN=000 at edge 12; re-release at edges 16, 18, 20; CYCLE_COUNT=20 at edge 20.
- USER_RSTN driven low mid-cycle at edge 5.5 -> all outputs return to reset values immediately, without waiting for a clock edge; after release the sequence restarts from edge 1.
- MAX_CYCLES=50, continuous ACTIVITY -> MAX_REACHED=1 at edge 50; with SIM_SEQ_AUTO_FINISH_EN, message printed and simulation ends at edge 50.
